// File: rtl/booth_mac_accum_if.sv
//------------------------------------------------------------------------------
// Module   : booth_mac_accum_if
// Brief    : Job control, operand-pair stream and result handshake bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface booth_mac_accum_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int LEN_WIDTH = 8
);
  logic                        start;
  logic [LEN_WIDTH-1:0]        len;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [WIDTH-1:0]     in_a;
  logic signed [WIDTH-1:0]     in_b;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] out_sum;
  logic                        out_ovf;
  logic                        busy;

  modport master (
    output start, len, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

`default_nettype wire

// File: rtl/booth_mac_accum.sv
//------------------------------------------------------------------------------
// Module   : booth_mac_accum
// Brief    : Radix-4 Booth multiplier with Brent-Kung final adder, followed by
//            a handshaked multiply-accumulate stage producing a dot product.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module booth_multiplier_8_PPA_Brent_Kung #(
  parameter int width = 8
) (
  input  logic signed [width-1:0]   X,
  input  logic signed [width-1:0]   Y,
  output logic signed [2*width-1:0] S
);
  localparam int c_pw = 2 * width;
  localparam int c_ng = (width + 1) / 2;
  localparam int c_yw = 2 * c_ng;
  localparam int c_np = 2 ** $clog2(c_pw);
  localparam int c_lg = $clog2(c_np);

  logic        [c_pw-1:0] w_x1;
  logic signed [c_yw-1:0] w_yext;
  logic        [c_yw:0]   w_ybits;
  logic        [c_pw-1:0] w_pp [c_ng];
  logic        [c_pw-1:0] w_pre;

  assign w_x1    = c_pw'(X);
  assign w_yext  = c_yw'(Y);
  assign w_ybits = {w_yext, 1'b0};

  // Each overlapping 3-bit window of Y selects a digit in {-2,-1,0,1,2}.
  for (genvar j = 0; j < c_ng; j++) begin : g_pp
    logic [2:0]      trip;
    logic [c_pw-1:0] sel;
    assign trip = w_ybits[2*j+2 -: 3];
    always_comb begin
      case (trip)
        3'b001, 3'b010: sel = w_x1;
        3'b011:         sel = w_x1 << 1;
        3'b100:         sel = -(w_x1 << 1);
        3'b101, 3'b110: sel = -w_x1;
        default:        sel = '0;
      endcase
    end
    assign w_pp[j] = sel << (2 * j);
  end

  always_comb begin
    w_pre = '0;
    for (int j = 0; j < c_ng - 1; j++) begin
      w_pre = w_pre + w_pp[j];
    end
  end

  function automatic logic [c_pw-1:0] bk_add(input logic [c_pw-1:0] a,
                                             input logic [c_pw-1:0] b);
    logic [c_np-1:0] g;
    logic [c_np-1:0] p;
    logic [c_np-1:0] p0;
    logic [c_np-1:0] s;
    g = '0;
    p = '0;
    s = '0;
    g[c_pw-1:0] = a & b;
    p[c_pw-1:0] = a ^ b;
    p0 = p;
    for (int l = 0; l < c_lg; l++) begin
      for (int i = 0; i < c_np; i++) begin
        if (((i + 1) % (1 << (l + 1))) == 0) begin
          g[i] = g[i] | (p[i] & g[i-(1<<l)]);
          p[i] = p[i] & p[i-(1<<l)];
        end
      end
    end
    // Down-sweep fills in the carries the up-sweep tree left unresolved.
    for (int l = c_lg - 2; l >= 0; l--) begin
      for (int i = 0; i < c_np; i++) begin
        if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && ((i + 1) > (1 << (l + 1)))) begin
          g[i] = g[i] | (p[i] & g[i-(1<<l)]);
        end
      end
    end
    s[0] = p0[0];
    for (int i = 1; i < c_np; i++) begin
      s[i] = p0[i] ^ g[i-1];
    end
    return s[c_pw-1:0];
  endfunction

  assign S = bk_add(w_pre, w_pp[c_ng-1]);
endmodule

module booth_mac_accum #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int LEN_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  booth_mac_accum_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [LEN_WIDTH-1:0]        r_cnt;
  logic signed [WIDTH-1:0]     r_a;
  logic signed [WIDTH-1:0]     r_b;
  logic                        r_pend;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic                        r_ovf;

  logic                        w_accept;
  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_add_ovf;

  booth_multiplier_8_PPA_Brent_Kung #(
    .width (WIDTH)
  ) u_mult (
    .X (r_a),
    .Y (r_b),
    .S (w_prod)
  );

  assign w_accept   = (r_state == RUN) && bus.in_valid;
  assign w_prod_ext = ACC_WIDTH'(w_prod);
  assign w_sum      = r_acc + w_prod_ext;
  assign w_add_ovf  = (r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                      (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = (bus.len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (w_accept && (r_cnt == LEN_WIDTH'(1))) begin
          w_next = DRAIN;
        end
      end
      DRAIN:   w_next = DONE;
      DONE: begin
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // A product registered at one edge is folded into the sum at the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_pend <= 1'b0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if ((r_state == IDLE) && bus.start) begin
        r_cnt  <= bus.len;
        r_acc  <= '0;
        r_ovf  <= 1'b0;
        r_pend <= 1'b0;
      end
      if ((r_state == RUN) || (r_state == DRAIN)) begin
        if (r_pend) begin
          r_acc <= w_sum;
          if (w_add_ovf) begin
            r_ovf <= 1'b1;
          end
        end
        r_pend <= w_accept;
      end
      if (w_accept) begin
        r_a   <= bus.in_a;
        r_b   <= bus.in_b;
        r_cnt <= r_cnt - LEN_WIDTH'(1);
      end
    end
  end

  assign bus.in_ready  = (r_state == RUN);
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_sum   = r_acc;
  assign bus.out_ovf   = r_ovf;
  assign bus.busy      = (r_state != IDLE);
endmodule

`default_nettype wire
